// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FFT constants, sequencer state encoding and bit-reverse helper
package fft_pkg;

  localparam int WORDSIZE   = 16;
  localparam int NUMSTAGES  = 5;
  localparam int NUMSAMPLES = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Reverses the low 'bits' bits of v; bits above are returned as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] v, input int bits);
    logic [31:0] r;
    logic [4:0]  idx;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < bits) begin
        idx  = 5'(bits - 1 - i);
        r[i] = v[idx];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/skid_fifo2.sv
// rtl/skid_fifo2.sv - two-entry FIFO catching registered RAM read data ahead of the output handshake
module skid_fifo2 #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] head,
  output logic [1:0]   count
);

  logic [W-1:0] mem [2];
  logic         wptr;
  logic         rptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wptr   <= 1'b0;
      rptr   <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= ~wptr;
      end
      if (pop) begin
        rptr <= ~rptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rptr];

endmodule

// File: rtl/fft_ram_sched.sv
// rtl/fft_ram_sched.sv - fills the stage sample RAM with one frame, then drains it in bit-reversed or linear order
module fft_ram_sched #(
  parameter int WORDSIZE = fft_pkg::WORDSIZE,
  parameter int ADDRSIZE = fft_pkg::NUMSTAGES,
  parameter int NUMADDR  = fft_pkg::NUMSAMPLES / 4,
  parameter int BITREV   = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORDSIZE-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORDSIZE-1:0] out_data,
  output logic [ADDRSIZE-1:0] ram_read_addr,
  output logic [ADDRSIZE-1:0] ram_write_addr,
  output logic                ram_rd_en,
  output logic                ram_wr_en,
  output logic                ram_cs,
  output logic [WORDSIZE-1:0] ram_data_in,
  input  logic [WORDSIZE-1:0] ram_data_out,
  output logic                busy,
  output logic                frame_done
);

  import fft_pkg::*;

  localparam int LOGN = $clog2(NUMADDR);
  localparam int CW   = LOGN + 1;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] wcnt;
  logic [CW-1:0] rcnt;
  logic          in_flight;
  logic [1:0]    skid_count;
  logic          hs;
  logic          pop;
  logic          issue;
  logic          last_pop;
  logic [2:0]    occ_after;
  logic [LOGN-1:0] rd_idx;

  assign in_ready  = !rst && (state == IDLE || state == FILL);
  assign hs        = in_valid && in_ready;
  assign out_valid = (skid_count != 2'd0);
  assign pop       = out_valid && out_ready;

  // Slots held or in flight after this cycle's pop; a new read may only claim a free one.
  assign occ_after = 3'(skid_count) + 3'(in_flight) - 3'(pop);
  assign issue     = (state == DRAIN) && (rcnt < CW'(NUMADDR)) && (occ_after < 3'd2);
  assign last_pop  = pop && (state == DRAIN) && (rcnt == CW'(NUMADDR)) &&
                     !in_flight && (skid_count == 2'd1);

  assign rd_idx = rcnt[LOGN-1:0];

  always_comb begin
    ram_read_addr = '0;
    if (BITREV != 0) begin
      ram_read_addr = ADDRSIZE'(bitrev(32'(rd_idx), LOGN));
    end else begin
      ram_read_addr = ADDRSIZE'(rd_idx);
    end
  end

  assign ram_write_addr = ADDRSIZE'(wcnt[LOGN-1:0]);
  assign ram_data_in    = in_data;
  assign ram_wr_en      = hs;
  assign ram_rd_en      = issue;
  assign ram_cs         = hs || issue;
  assign busy           = (state == FILL) || (state == DRAIN);
  assign frame_done     = last_pop;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = FILL;
      FILL:    if (hs && wcnt == CW'(NUMADDR - 1)) state_nxt = DRAIN;
      DRAIN:   if (last_pop) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      wcnt      <= '0;
      rcnt      <= '0;
      in_flight <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_flight <= issue;
      if (hs) begin
        if (wcnt == CW'(NUMADDR - 1)) wcnt <= '0;
        else                          wcnt <= wcnt + 1'b1;
      end
      if (last_pop)   rcnt <= '0;
      else if (issue) rcnt <= rcnt + 1'b1;
    end
  end

  skid_fifo2 #(
    .W (WORDSIZE)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (in_flight),
    .push_data (ram_data_out),
    .pop       (pop),
    .head      (out_data),
    .count     (skid_count)
  );

endmodule

// File: tb/tb_fft_ram_sched.sv
// tb/tb_fft_ram_sched.sv - directed bench driving bit-reversed and sequential instances in lockstep
module tb_fft_ram_sched;

  localparam int W = 16;
  localparam int A = 5;
  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b0;

  logic         b_ir, b_ov, b_rd, b_wr, b_cs, b_busy, b_fdp;
  logic [W-1:0] b_od, b_din, b_rdata;
  logic [A-1:0] b_raddr, b_waddr;
  logic         s_ir, s_ov, s_rd, s_wr, s_cs, s_busy, s_fdp;
  logic [W-1:0] s_od, s_din, s_rdata;
  logic [A-1:0] s_raddr, s_waddr;

  logic [W-1:0] b_mem [32];
  logic [W-1:0] s_mem [32];

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fft_ram_sched #(.WORDSIZE(W), .ADDRSIZE(A), .NUMADDR(N), .BITREV(1)) u_bit (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ir), .in_data(in_data),
    .out_valid(b_ov), .out_ready(out_ready), .out_data(b_od),
    .ram_read_addr(b_raddr), .ram_write_addr(b_waddr), .ram_rd_en(b_rd), .ram_wr_en(b_wr),
    .ram_cs(b_cs), .ram_data_in(b_din), .ram_data_out(b_rdata), .busy(b_busy), .frame_done(b_fdp)
  );

  fft_ram_sched #(.WORDSIZE(W), .ADDRSIZE(A), .NUMADDR(N), .BITREV(0)) u_seq (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_ir), .in_data(in_data),
    .out_valid(s_ov), .out_ready(out_ready), .out_data(s_od),
    .ram_read_addr(s_raddr), .ram_write_addr(s_waddr), .ram_rd_en(s_rd), .ram_wr_en(s_wr),
    .ram_cs(s_cs), .ram_data_in(s_din), .ram_data_out(s_rdata), .busy(s_busy), .frame_done(s_fdp)
  );

  always @(posedge clk) begin
    if (b_wr) b_mem[b_waddr] <= b_din;
    if (b_rd) b_rdata <= b_mem[b_raddr];
    if (s_wr) s_mem[s_waddr] <= s_din;
    if (s_rd) s_rdata <= s_mem[s_raddr];
  end

  logic [W-1:0] b_q[$], s_q[$];
  logic [A-1:0] b_ra[$], s_ra[$];
  int b_fd = 0, s_fd = 0, inv_err = 0;
  int b_iss = 0, b_pop = 0, s_iss = 0, s_pop = 0;
  logic b_hold = 1'b0, s_hold = 1'b0;
  logic [W-1:0] b_hold_data = '0, s_hold_data = '0;

  always @(negedge clk) begin
    if ((b_rd && b_wr) || (b_cs !== (b_rd | b_wr))) inv_err++;
    if ((s_rd && s_wr) || (s_cs !== (s_rd | s_wr))) inv_err++;
    if (rst) begin
      b_iss = 0; b_pop = 0; s_iss = 0; s_pop = 0;
      b_hold = 1'b0; s_hold = 1'b0;
    end else begin
      if (b_rd) begin b_iss++; b_ra.push_back(b_raddr); end
      if (s_rd) begin s_iss++; s_ra.push_back(s_raddr); end
      if (b_ov && out_ready) begin b_pop++; b_q.push_back(b_od); end
      if (s_ov && out_ready) begin s_pop++; s_q.push_back(s_od); end
      if (b_iss - b_pop > 2) inv_err++;
      if (s_iss - s_pop > 2) inv_err++;
      if (b_hold && (!b_ov || b_od !== b_hold_data)) inv_err++;
      if (s_hold && (!s_ov || s_od !== s_hold_data)) inv_err++;
      b_hold = b_ov && !out_ready; b_hold_data = b_od;
      s_hold = s_ov && !out_ready; s_hold_data = s_od;
      if (b_fdp) begin b_fd++; b_iss = 0; b_pop = 0; end
      if (s_fdp) begin s_fd++; s_iss = 0; s_pop = 0; end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int br3(input int k);
    return ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
  endfunction

  task automatic fill(input logic [W-1:0] base, input logic [7:0] gaps);
    for (int i = 0; i < N; i++) begin
      if (gaps[i]) begin
        in_valid = 1'b0;
        @(negedge clk);
        check("gap_no_write", 32'({b_wr, s_wr}), 32'd0);
        tick;
      end
      in_valid = 1'b1;
      in_data  = base ^ W'(i);
      @(negedge clk);
      check("fill_ready", 32'({b_ir, s_ir}), 32'b11);
      check("fill_wr_en", 32'({b_wr, s_wr}), 32'b11);
      check("fill_waddr", 32'(b_waddr), 32'(i));
      check("fill_wdata", 32'(b_din), 32'(base ^ W'(i)));
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain(input logic [3:0] rdy_pat, input logic next_valid, input logic [W-1:0] next_data);
    int c, first_ov, wr_seen;
    bit done;
    c = 0; first_ov = -1; wr_seen = 0; done = 1'b0;
    in_valid = next_valid;
    in_data  = next_data;
    while (!done && c < 40) begin
      out_ready = rdy_pat[2'(c)];
      @(negedge clk);
      if (c == 0) begin
        check("drain_busy", 32'({b_busy, s_busy}), 32'b11);
        check("drain_in_ready", 32'({b_ir, s_ir}), 32'd0);
        check("drain_first_read", 32'({b_rd, s_rd}), 32'b11);
      end
      if (first_ov < 0 && b_ov) first_ov = c;
      if (b_wr || s_wr) wr_seen++;
      if (b_fdp) begin
        done = 1'b1;
        check("fd_in_ready_low", 32'({b_ir, s_ir}), 32'd0);
        check("fd_lockstep", 32'(s_fdp), 32'd1);
      end
      tick;
      c++;
    end
    check("drain_done_in_time", 32'(done), 32'd1);
    check("first_out_latency", 32'(first_ov), 32'd2);
    check("no_write_in_drain", 32'(wr_seen), 32'd0);
  endtask

  task automatic verify(input logic [W-1:0] base);
    check("bit_word_count", 32'(b_q.size()), 32'd8);
    check("seq_word_count", 32'(s_q.size()), 32'd8);
    check("bit_read_count", 32'(b_ra.size()), 32'd8);
    check("seq_read_count", 32'(s_ra.size()), 32'd8);
    for (int k = 0; k < N; k++) begin
      if (k < b_q.size())  check("bit_data", 32'(b_q[k]), 32'(base ^ W'(br3(k))));
      if (k < s_q.size())  check("seq_data", 32'(s_q[k]), 32'(base ^ W'(k)));
      if (k < b_ra.size()) check("bit_raddr", 32'(b_ra[k]), 32'(br3(k)));
      if (k < s_ra.size()) check("seq_raddr", 32'(s_ra[k]), 32'(k));
    end
    check("bit_frame_done_once", 32'(b_fd), 32'd1);
    check("seq_frame_done_once", 32'(s_fd), 32'd1);
    check("strobe_invariants", 32'(inv_err), 32'd0);
    b_q.delete(); s_q.delete(); b_ra.delete(); s_ra.delete();
    b_fd = 0; s_fd = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end of the sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) tick;
    @(negedge clk);
    check("rst_in_ready", 32'({b_ir, s_ir}), 32'd0);
    check("rst_out_valid", 32'({b_ov, s_ov}), 32'd0);
    check("rst_busy", 32'({b_busy, s_busy}), 32'd0);
    check("rst_strobes", 32'({b_cs, b_rd, b_wr, s_cs, s_rd, s_wr}), 32'd0);
    check("rst_frame_done", 32'({b_fdp, s_fdp}), 32'd0);
    check("rst_addrs", 32'({b_raddr, b_waddr, s_raddr, s_waddr}), 32'd0);
    check("rst_data", 32'({b_od, s_od}), 32'd0);
    tick;
    rst = 1'b0;
    @(negedge clk);
    check("idle_ready", 32'({b_ir, s_ir}), 32'b11);
    tick;

    fill(16'hFFFF, 8'b0000_0000);
    drain(4'b1111, 1'b0, '0);
    verify(16'hFFFF);

    fill(16'h5A30, 8'b0000_0000);
    drain(4'b1001, 1'b0, '0);
    verify(16'h5A30);

    fill(16'h1234, 8'b1011_0110);
    drain(4'b1111, 1'b0, '0);
    verify(16'h1234);

    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 16'hC000 | W'(i);
      tick;
    end
    in_valid = 1'b0;
    in_data  = '0;
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready_gated", 32'({b_ir, s_ir}), 32'd0);
    tick;
    @(negedge clk);
    check("abort_in_ready", 32'({b_ir, s_ir}), 32'd0);
    check("abort_busy", 32'({b_busy, s_busy}), 32'd0);
    check("abort_out_valid", 32'({b_ov, s_ov}), 32'd0);
    check("abort_strobes", 32'({b_cs, b_rd, b_wr, s_cs, s_rd, s_wr}), 32'd0);
    check("abort_frame_done", 32'({b_fdp, s_fdp}), 32'd0);
    check("abort_addrs_data", 32'({b_raddr, b_waddr, b_od}), 32'd0);
    tick;
    rst = 1'b0;
    check("abort_no_fd_count", 32'(b_fd + s_fd), 32'd0);
    check("abort_no_outputs", 32'(b_q.size() + s_q.size()), 32'd0);
    @(negedge clk);
    check("abort_idle_ready", 32'({b_ir, s_ir}), 32'b11);
    tick;
    fill(16'hA0C0, 8'b0000_0000);
    drain(4'b1111, 1'b0, '0);
    verify(16'hA0C0);

    fill(16'h0F00, 8'b0000_0000);
    drain(4'b1111, 1'b1, 16'h7700);
    verify(16'h0F00);
    fill(16'h7700, 8'b0000_0000);
    drain(4'b1001, 1'b0, '0);
    verify(16'h7700);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fft_ram_sched.md
Name: fft_ram_sched

Overview:
Sequencer that owns one sample RAM. The RAM has separate read/write address ports, rd_en/wr_en/cs strobes, and a 1-cycle registered read. The block fills the RAM with one frame of NUMADDR words from an upstream valid/ready stream. It then drains the frame to the downstream butterfly stage in bit-reversed (or sequential) order, with backpressure. One instance sits in front of each FFT stage buffer.

Parameters:
WORDSIZE, 16, sample word width
ADDRSIZE, 5, RAM address width (NUMSTAGES)
NUMADDR, 8, words per frame (NUMSAMPLES/4); power of two, ≤ 2^ADDRSIZE
BITREV, 1, 1 = drain in bit-reversed order over log2(NUMADDR) bits; 0 = sequential

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream word valid
in_ready  out  1  block accepts upstream word
in_data  in  WORDSIZE  upstream word
out_valid  out  1  downstream word valid
out_ready  in  1  downstream accepts word
out_data  out  WORDSIZE  downstream word
ram_read_addr  out  ADDRSIZE  RAM read address
ram_write_addr  out  ADDRSIZE  RAM write address
ram_rd_en  out  1  RAM read strobe
ram_wr_en  out  1  RAM write strobe
ram_cs  out  1  RAM chip select
ram_data_in  out  WORDSIZE  RAM write data
ram_data_out  in  WORDSIZE  RAM read data, valid the cycle after ram_rd_en
busy  out  1  high in FILL or DRAIN
frame_done  out  1  one-cycle pulse at end of drain

Behaviour:
- Reset: state=IDLE. Write counter, read counter, in-flight flag and skid buffer are cleared. All outputs are 0, including in_ready. Reset mid-frame aborts the frame and discards buffered words; no frame_done is issued.
- States: IDLE, FILL, DRAIN.
- in_ready=1 in IDLE and FILL only. Handshake occurs on in_valid&in_ready.
- IDLE: a handshake writes in_data to address 0, sets wcnt=1, and moves to FILL.
- FILL: each handshake writes at address wcnt, then wcnt++. A handshake with wcnt=NUMADDR-1 moves to DRAIN and clears wcnt. Gaps in in_valid stall without side effects.
- Write path is combinational from the handshake: ram_wr_en=handshake, ram_write_addr=wcnt zero-extended, ram_data_in=in_data.
- DRAIN, read issue: a read is issued when rcnt<NUMADDR and (skid count + in-flight) < 2, counting a same-cycle pop as freeing a slot.
  - ram_rd_en=issue.
  - ram_read_addr=bitrev(rcnt[log2 NUMADDR-1:0]) when BITREV=1, else rcnt. Upper bits are zero.
  - rcnt++ on issue.
- In-flight flag: set the cycle after issue. ram_data_out is pushed into the 2-entry skid FIFO that cycle.
- out_valid=skid non-empty; out_data=skid head. Pop on out_valid&out_ready.
- Latency: first out_valid 2 cycles after DRAIN entry. With out_ready held at 1, one word per cycle follows with no bubbles.
- Backpressure: when out_ready=0, reads stop once 2 words are held or in flight. No word is lost or duplicated.
- End of drain: on the pop of the NUMADDR-th word, frame_done pulses for 1 cycle and state returns to IDLE. in_ready=1 the next cycle, so back-to-back frames lose 1 cycle.
- In IDLE, in_valid is never simultaneous with draining, so no read/write address conflict exists.
- ram_cs=ram_rd_en|ram_wr_en. Both strobes are never high in the same cycle.
- Counters are log2(NUMADDR)+1 bits wide and never wrap within a frame.

Decomposition:
- Shared package fft_pkg holds:
  - WORDSIZE, NUMSTAGES, NUMSAMPLES constants
  - state encoding localparams (IDLE=2'd0, FILL=2'd1, DRAIN=2'd2)
  - bitrev function (width-parameterised)
- One sub-module: skid_fifo2, a 2-entry FIFO with push, pop, head, count.
- FSM, counters and RAM strobes stay in fft_ram_sched.

Test Plan:
- Fill, in_valid held 1: in_data 0xFFFF, 0xFFFE … 0xFFF8; BITREV=1; out_ready=1.
  -> ram_wr_en 8 consecutive cycles at write addresses 0–7.
  -> Outputs in order 0xFFFF, 0xFFFB, 0xFFFD, 0xFFF9, 0xFFFE, 0xFFFA, 0xFFFC, 0xFFF8.
  -> First out_valid 2 cycles after DRAIN entry; frame_done once.
- Same frame with BITREV=0 -> outputs 0xFFFF down to 0xFFF8 in sequential order; read addresses 0–7.
- out_ready toggling 1,0,0,1 during drain -> all 8 words delivered exactly once and in order; never more than 2 reads outstanding; out_data stable while out_valid&!out_ready.
- in_valid with random gaps during fill -> writes only on handshake; DRAIN entered exactly after the 8th handshake.
- rst asserted after 5 words written -> next cycle: state IDLE, all outputs 0, no frame_done. A new full frame afterwards drains correctly.
- Two frames back-to-back -> second frame accepted 1 cycle after frame_done; ram_rd_en and ram_wr_en never high together; ram_cs equals their OR throughout.
